// File: rtl/mem_pkg.sv
// Shared types and defaults for the memory responder and its RAM.
package mem_pkg;

  localparam int unsigned WORD_SIZE_DEF = 16;
  localparam logic [15:0] IO_ADDR_DEF   = 16'hFFFF;
  // Wait-state counter width; bounds WAIT_STATES to 0..15.
  localparam int unsigned CNT_W         = 4;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StWait = 2'd1,
    StResp = 2'd2
  } state_e;

endpackage

// File: rtl/mem_array.sv
// Single-port synchronous RAM with a registered read port.
module mem_array
  import mem_pkg::*;
#(
  parameter int unsigned WORD_SIZE = WORD_SIZE_DEF,
  parameter int unsigned ADDR_BITS = 8,
  parameter string       INIT_FILE = ""
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic                 re,
  input  logic [ADDR_BITS-1:0] addr,
  input  logic [WORD_SIZE-1:0] wdata,
  output logic [WORD_SIZE-1:0] rdata
);

  localparam int unsigned Depth = 2 ** ADDR_BITS;

  logic [WORD_SIZE-1:0] r_mem [Depth];
  logic [WORD_SIZE-1:0] r_q;

  // Write port and registered read; r_q only changes on a read so it holds between reads.
  always_ff @(posedge clk) begin
    if (we) r_mem[addr] <= wdata;
    if (re) r_q <= r_mem[addr];
  end

  assign rdata = r_q;

endmodule

// File: rtl/memory_responder.sv
// Word-addressed memory responder: request capture, wait states, one-cycle response,
// RAM / memory-mapped I/O decode and a synchronised input port.
module memory_responder
  import mem_pkg::*;
#(
  parameter int unsigned          WORD_SIZE   = WORD_SIZE_DEF,
  parameter int unsigned          ADDR_BITS   = 8,
  parameter int unsigned          WAIT_STATES = 1,
  parameter logic [WORD_SIZE-1:0] IO_ADDR     = WORD_SIZE'(IO_ADDR_DEF),
  parameter string                INIT_FILE   = ""
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req,
  input  logic                 we,
  input  logic [WORD_SIZE-1:0] addr,
  input  logic [WORD_SIZE-1:0] wdata,
  output logic [WORD_SIZE-1:0] rdata,
  output logic                 ready,
  output logic                 err,
  input  logic [WORD_SIZE-1:0] io_in,
  output logic [WORD_SIZE-1:0] io_out
);

  if (WAIT_STATES > (2 ** CNT_W) - 1) begin : g_ws_check
    $error("memory_responder: WAIT_STATES must be in 0..15");
  end
  if (ADDR_BITS >= WORD_SIZE) begin : g_ab_check
    $error("memory_responder: ADDR_BITS must be smaller than WORD_SIZE");
  end

  state_e               r_state;
  logic [CNT_W-1:0]     r_cnt;
  logic [WORD_SIZE-1:0] r_addr;
  logic                 r_we;
  logic [WORD_SIZE-1:0] r_wdata;
  logic                 r_ready;
  logic                 r_err;
  logic                 r_rd_sel_ram;
  logic [WORD_SIZE-1:0] r_rdata_oth;
  logic [WORD_SIZE-1:0] r_io_out;
  logic [WORD_SIZE-1:0] r_sync1;
  logic [WORD_SIZE-1:0] r_sync2;

  logic                 w_enter_resp;
  logic [WORD_SIZE-1:0] w_acc_addr;
  logic                 w_acc_we;
  logic [WORD_SIZE-1:0] w_acc_wdata;
  logic                 w_is_io;
  logic                 w_is_ram;
  logic                 w_ram_we;
  logic                 w_ram_re;
  logic [WORD_SIZE-1:0] w_ram_q;

  // Select the access being answered and decode it. With zero wait states the response
  // edge is the capture edge, so the live request inputs are used while idle.
  always_comb begin
    w_enter_resp = 1'b0;
    if (r_state == StIdle) begin
      w_enter_resp = req && (WAIT_STATES == 0);
    end else if (r_state == StWait) begin
      w_enter_resp = (r_cnt == '0);
    end
    w_acc_addr  = (r_state == StIdle) ? addr  : r_addr;
    w_acc_we    = (r_state == StIdle) ? we    : r_we;
    w_acc_wdata = (r_state == StIdle) ? wdata : r_wdata;
    // I/O decode wins over RAM decode.
    w_is_io  = (w_acc_addr == IO_ADDR);
    w_is_ram = !w_is_io && (w_acc_addr[WORD_SIZE-1:ADDR_BITS] == '0);
    // Gate with rst_n so a reset edge drops an access that would have committed.
    w_ram_we = rst_n && w_enter_resp && w_acc_we && w_is_ram;
    w_ram_re = rst_n && w_enter_resp && !w_acc_we && w_is_ram;
  end

  mem_array #(
    .WORD_SIZE(WORD_SIZE),
    .ADDR_BITS(ADDR_BITS),
    .INIT_FILE(INIT_FILE)
  ) u_mem_array (
    .clk  (clk),
    .we   (w_ram_we),
    .re   (w_ram_re),
    .addr (w_acc_addr[ADDR_BITS-1:0]),
    .wdata(w_acc_wdata),
    .rdata(w_ram_q)
  );

  // Two-flop synchroniser for the asynchronous input port.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= io_in;
      r_sync2 <= r_sync1;
    end
  end

  // Access FSM with registered response, I/O output and read-data source.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= StIdle;
      r_cnt        <= '0;
      r_addr       <= '0;
      r_we         <= 1'b0;
      r_wdata      <= '0;
      r_ready      <= 1'b0;
      r_err        <= 1'b0;
      r_rd_sel_ram <= 1'b0;
      r_rdata_oth  <= '0;
      r_io_out     <= '0;
    end else begin
      r_ready <= 1'b0;
      r_err   <= 1'b0;
      if (w_enter_resp) begin
        r_ready <= 1'b1;
        r_err   <= !w_is_io && !w_is_ram;
        if (w_acc_we) begin
          if (w_is_io) r_io_out <= w_acc_wdata;
        end else begin
          r_rd_sel_ram <= w_is_ram;
          r_rdata_oth  <= w_is_io ? r_sync2 : '0;
        end
      end
      unique case (r_state)
        StIdle: begin
          if (req) begin
            r_addr  <= addr;
            r_we    <= we;
            r_wdata <= wdata;
            if (WAIT_STATES == 0) begin
              r_state <= StResp;
            end else begin
              r_cnt   <= CNT_W'(WAIT_STATES - 1);
              r_state <= StWait;
            end
          end
        end
        StWait: begin
          if (r_cnt == '0) begin
            r_state <= StResp;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        StResp:  r_state <= StIdle;
        default: r_state <= StIdle;
      endcase
    end
  end

  // RAM reads come straight from the RAM's read register; other reads from r_rdata_oth.
  assign rdata  = r_rd_sel_ram ? w_ram_q : r_rdata_oth;
  assign ready  = r_ready;
  assign err    = r_err;
  assign io_out = r_io_out;

endmodule

// File: tb/tb_memory_responder.sv
// Directed bench: four responders (WAIT_STATES 1, 0, 3, 15) share one stimulus bus.
module tb_memory_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req;
  logic        we;
  logic [15:0] addr;
  logic [15:0] wdata;
  logic [15:0] io_in;
  logic [15:0] rdata  [4];
  logic        ready  [4];
  logic        err    [4];
  logic [15:0] io_out [4];

  int n_assert = 0;
  int n_fail   = 0;
  int ws_exp [4] = '{1, 0, 3, 15};

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int unsigned Ws = (g == 0) ? 1 : (g == 1) ? 0 : (g == 2) ? 3 : 15;
    memory_responder #(
      .WORD_SIZE  (16),
      .ADDR_BITS  (8),
      .WAIT_STATES(Ws),
      .IO_ADDR    (16'hFFFF),
      .INIT_FILE  ("")
    ) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .req   (req),
      .we    (we),
      .addr  (addr),
      .wdata (wdata),
      .rdata (rdata[g]),
      .ready (ready[g]),
      .err   (err[g]),
      .io_in (io_in),
      .io_out(io_out[g])
    );
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
  endtask

  // Issue one request; return at the first cycle ready is seen on DUT idx (bounded).
  task automatic access(input int idx, input logic w, input logic [15:0] a,
                        input logic [15:0] d, input bit pulse, output int lat,
                        output logic [15:0] rd, output logic er);
    req   = 1'b1;
    we    = w;
    addr  = a;
    wdata = d;
    tick();
    req = 1'b0;
    lat = 0;
    while (ready[idx] !== 1'b1 && lat < 40) begin
      if (pulse) req = ~req;
      tick();
      lat++;
    end
    req = 1'b0;
    rd  = rdata[idx];
    er  = err[idx];
  endtask

  // Response must be exactly one cycle wide and err must drop with it.
  task automatic end_access(input int idx, input string tag);
    tick();
    chk({tag, "_ready_drop"}, 32'(ready[idx]), 32'd0);
    chk({tag, "_err_drop"}, 32'(err[idx]), 32'd0);
  endtask

  initial begin
    int          lat;
    logic [15:0] rd;
    logic        er;
    int          n_extra;

    rst_n = 1'b0; req = 1'b0; we = 1'b0; addr = '0; wdata = '0; io_in = '0;
    do_reset();
    chk("rst_ready", 32'(ready[0]), 32'd0);
    chk("rst_rdata", 32'(rdata[0]), 32'd0);

    // Seed state so the reset check below can see things clear.
    access(0, 1'b1, 16'h0003, 16'h1111, 1'b0, lat, rd, er);
    end_access(0, "seed_wr");
    access(0, 1'b1, 16'hFFFF, 16'h0F0F, 1'b0, lat, rd, er);
    end_access(0, "seed_io");
    access(0, 1'b0, 16'h0003, 16'h0000, 1'b0, lat, rd, er);
    chk("seed_rd", 32'(rd), 32'h1111);
    end_access(0, "seed_rd");

    // Reset held for two edges with a write request pending.
    rst_n = 1'b0; req = 1'b1; we = 1'b1; addr = 16'h0003; wdata = 16'hDEAD;
    repeat (2) tick();
    chk("rstreq_ready", 32'(ready[0]), 32'd0);
    chk("rstreq_err", 32'(err[0]), 32'd0);
    chk("rstreq_rdata", 32'(rdata[0]), 32'd0);
    chk("rstreq_io_out", 32'(io_out[0]), 32'd0);
    req = 1'b0; rst_n = 1'b1;
    tick();
    access(0, 1'b0, 16'h0003, 16'h0000, 1'b0, lat, rd, er);
    chk("rstreq_no_write", 32'(rd), 32'h1111);
    end_access(0, "rstreq_rd");

    // Write then read, one wait state.
    access(0, 1'b1, 16'h0012, 16'hBEEF, 1'b0, lat, rd, er);
    chk("wr12_lat", 32'(lat), 32'd1);
    chk("wr12_err", 32'(er), 32'd0);
    end_access(0, "wr12");
    access(0, 1'b0, 16'h0012, 16'h0000, 1'b0, lat, rd, er);
    chk("rd12_lat", 32'(lat), 32'd1);
    chk("rd12_data", 32'(rd), 32'hBEEF);
    chk("rd12_err", 32'(er), 32'd0);
    end_access(0, "rd12");

    // Latency sweep with stray req pulses while waiting.
    for (int i = 1; i < 4; i++) begin
      do_reset();
      access(i, 1'b0, 16'h0012, 16'h0000, 1'b1, lat, rd, er);
      chk($sformatf("sweep%0d_lat", ws_exp[i]), 32'(lat), 32'(ws_exp[i]));
      chk($sformatf("sweep%0d_err", ws_exp[i]), 32'(er), 32'd0);
      n_extra = 0;
      repeat (20) begin
        tick();
        if (ready[i] === 1'b1) n_extra++;
      end
      chk($sformatf("sweep%0d_no_second_ready", ws_exp[i]), 32'(n_extra), 32'd0);
    end

    // I/O port write and synchronised read.
    do_reset();
    access(0, 1'b1, 16'hFFFF, 16'h00A5, 1'b0, lat, rd, er);
    chk("io_wr_out", 32'(io_out[0]), 32'h00A5);
    chk("io_wr_err", 32'(er), 32'd0);
    end_access(0, "io_wr");
    io_in = 16'h1234;
    repeat (3) tick();
    access(0, 1'b0, 16'hFFFF, 16'h0000, 1'b0, lat, rd, er);
    chk("io_rd_data", 32'(rd), 32'h1234);
    chk("io_rd_err", 32'(er), 32'd0);
    end_access(0, "io_rd");

    // Unmapped accesses must not alias onto RAM word 0.
    access(0, 1'b1, 16'h0000, 16'h0A0A, 1'b0, lat, rd, er);
    end_access(0, "w0");
    access(0, 1'b1, 16'h0100, 16'h5555, 1'b0, lat, rd, er);
    chk("unm_wr_err", 32'(er), 32'd1);
    end_access(0, "unm_wr");
    access(0, 1'b0, 16'h0100, 16'h0000, 1'b0, lat, rd, er);
    chk("unm_rd_err", 32'(er), 32'd1);
    chk("unm_rd_data", 32'(rd), 32'd0);
    end_access(0, "unm_rd");
    access(0, 1'b0, 16'h0000, 16'h0000, 1'b0, lat, rd, er);
    chk("w0_intact", 32'(rd), 32'h0A0A);
    chk("w0_err", 32'(er), 32'd0);
    chk("unm_io_kept", 32'(io_out[0]), 32'h00A5);
    end_access(0, "w0_rd");

    // Reset during WAIT drops the pending write (three wait states).
    do_reset();
    access(2, 1'b1, 16'h0005, 16'h1357, 1'b0, lat, rd, er);
    end_access(2, "ws3_seed");
    req = 1'b1; we = 1'b1; addr = 16'h0005; wdata = 16'h7777;
    tick();
    req = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    n_extra = 0;
    repeat (6) begin
      tick();
      if (ready[2] === 1'b1) n_extra++;
    end
    chk("midrst_no_ready", 32'(n_extra), 32'd0);
    access(2, 1'b0, 16'h0005, 16'h0000, 1'b0, lat, rd, er);
    chk("midrst_lat", 32'(lat), 32'd3);
    chk("midrst_old_value", 32'(rd), 32'h1357);
    end_access(2, "midrst_rd");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
